// File: rtl/green_extent_tracker_if.sv
// Pixel stream in, published bounding-box results out, for green_extent_tracker.
// master drives pixels and reads results; slave is the tracker.
interface green_extent_tracker_if;
    logic        in_valid;
    logic        detected;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  left;
    logic [9:0]  right;
    logic [9:0]  top;
    logic [9:0]  bottom;
    logic [18:0] pix_count;
    logic        box_valid;
    logic        frame_done;
    logic        sync_err;

    modport master (
        output in_valid, detected, x, y,
        input  left, right, top, bottom, pix_count, box_valid, frame_done, sync_err
    );

    modport slave (
        input  in_valid, detected, x, y,
        output left, right, top, bottom, pix_count, box_valid, frame_done, sync_err
    );
endinterface

// File: rtl/green_extent_tracker.sv
// Tracks the bounding box and count of green-detected pixels over a raster frame
// and publishes them once per completed (0,0)..(H-1,V-1) frame.
module green_extent_tracker #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned MIN_COUNT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    green_extent_tracker_if.slave px_if
);

    localparam int unsigned PW = 10;
    localparam int unsigned CW = 19;

    localparam logic [PW:0]   X_LIM   = (PW+1)'(H_ACTIVE);
    localparam logic [PW:0]   Y_LIM   = (PW+1)'(V_ACTIVE);
    localparam logic [PW-1:0] X_LAST  = PW'(H_ACTIVE - 1);
    localparam logic [PW-1:0] Y_LAST  = PW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] MIN_CNT = CW'(MIN_COUNT);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACCUM    = 2'd1,
        PUBLISH  = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic [PW-1:0]   r_left, r_right, r_top, r_bottom;
    logic [PW-1:0]   w_left_nxt, w_right_nxt, w_top_nxt, w_bottom_nxt;
    logic            r_sync_err, w_sync_err_nxt;

    logic [PW-1:0]   r_o_left, r_o_right, r_o_top, r_o_bottom;
    logic [CW-1:0]   r_o_pix_count;
    logic            r_o_box_valid, r_o_frame_done;

    logic            w_take, w_sof, w_eof, w_meets;

    // First-pixel load values and running-accumulate values for the current pixel.
    logic [CW-1:0]   w_ld_count, w_ac_count;
    logic [PW-1:0]   w_ld_left, w_ld_right, w_ld_top, w_ld_bottom;
    logic [PW-1:0]   w_ac_left, w_ac_right, w_ac_top, w_ac_bottom;

    assign w_take  = px_if.in_valid
                   && ({1'b0, px_if.x} < X_LIM)
                   && ({1'b0, px_if.y} < Y_LIM);
    assign w_sof   = w_take && (px_if.x == '0) && (px_if.y == '0);
    assign w_eof   = w_take && (px_if.x == X_LAST) && (px_if.y == Y_LAST);
    assign w_meets = (r_count >= MIN_CNT);

    always_comb begin
        w_ld_count  = '0;
        w_ld_left   = '0;
        w_ld_right  = '0;
        w_ld_top    = '0;
        w_ld_bottom = '0;
        if (px_if.detected) begin
            w_ld_count  = CW'(1);
            w_ld_left   = px_if.x;
            w_ld_right  = px_if.x;
            w_ld_top    = px_if.y;
            w_ld_bottom = px_if.y;
        end
    end

    // Empty accumulator seeds the box from this pixel; otherwise widen it.
    always_comb begin
        w_ac_count  = r_count;
        w_ac_left   = r_left;
        w_ac_right  = r_right;
        w_ac_top    = r_top;
        w_ac_bottom = r_bottom;
        if (px_if.detected) begin
            if (r_count == '0) begin
                w_ac_left   = px_if.x;
                w_ac_right  = px_if.x;
                w_ac_top    = px_if.y;
                w_ac_bottom = px_if.y;
            end else begin
                if (px_if.x < r_left)   w_ac_left   = px_if.x;
                if (px_if.x > r_right)  w_ac_right  = px_if.x;
                if (px_if.y < r_top)    w_ac_top    = px_if.y;
                if (px_if.y > r_bottom) w_ac_bottom = px_if.y;
            end
            if (r_count != CNT_MAX) w_ac_count = r_count + CW'(1);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_left_nxt     = r_left;
        w_right_nxt    = r_right;
        w_top_nxt      = r_top;
        w_bottom_nxt   = r_bottom;
        w_sync_err_nxt = 1'b0;

        case (r_state)
            WAIT_SOF: begin
                if (w_sof) begin
                    w_count_nxt  = w_ld_count;
                    w_left_nxt   = w_ld_left;
                    w_right_nxt  = w_ld_right;
                    w_top_nxt    = w_ld_top;
                    w_bottom_nxt = w_ld_bottom;
                    w_state_nxt  = ACCUM;
                end
            end
            ACCUM: begin
                if (w_sof) begin
                    // Restart without frame end: drop the partial frame.
                    w_count_nxt    = w_ld_count;
                    w_left_nxt     = w_ld_left;
                    w_right_nxt    = w_ld_right;
                    w_top_nxt      = w_ld_top;
                    w_bottom_nxt   = w_ld_bottom;
                    w_sync_err_nxt = ~r_sync_err;
                end else if (w_take) begin
                    w_count_nxt  = w_ac_count;
                    w_left_nxt   = w_ac_left;
                    w_right_nxt  = w_ac_right;
                    w_top_nxt    = w_ac_top;
                    w_bottom_nxt = w_ac_bottom;
                    if (w_eof) w_state_nxt = PUBLISH;
                end
            end
            PUBLISH: begin
                if (w_sof) begin
                    w_count_nxt  = w_ld_count;
                    w_left_nxt   = w_ld_left;
                    w_right_nxt  = w_ld_right;
                    w_top_nxt    = w_ld_top;
                    w_bottom_nxt = w_ld_bottom;
                    w_state_nxt  = ACCUM;
                end else begin
                    w_count_nxt  = '0;
                    w_left_nxt   = '0;
                    w_right_nxt  = '0;
                    w_top_nxt    = '0;
                    w_bottom_nxt = '0;
                    w_state_nxt  = w_take ? WAIT_SOF : ACCUM;
                end
            end
            default: begin
                w_state_nxt  = WAIT_SOF;
                w_count_nxt  = '0;
                w_left_nxt   = '0;
                w_right_nxt  = '0;
                w_top_nxt    = '0;
                w_bottom_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= WAIT_SOF;
            r_count    <= '0;
            r_left     <= '0;
            r_right    <= '0;
            r_top      <= '0;
            r_bottom   <= '0;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_left     <= w_left_nxt;
            r_right    <= w_right_nxt;
            r_top      <= w_top_nxt;
            r_bottom   <= w_bottom_nxt;
            r_sync_err <= w_sync_err_nxt;
        end
    end

    // Published results; extents only move when the frame met the minimum count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_o_left       <= '0;
            r_o_right      <= '0;
            r_o_top        <= '0;
            r_o_bottom     <= '0;
            r_o_pix_count  <= '0;
            r_o_box_valid  <= 1'b0;
            r_o_frame_done <= 1'b0;
        end else if (r_state == PUBLISH) begin
            r_o_pix_count  <= r_count;
            r_o_box_valid  <= w_meets;
            r_o_frame_done <= 1'b1;
            if (w_meets) begin
                r_o_left   <= r_left;
                r_o_right  <= r_right;
                r_o_top    <= r_top;
                r_o_bottom <= r_bottom;
            end
        end else begin
            r_o_frame_done <= 1'b0;
        end
    end

    assign px_if.left       = r_o_left;
    assign px_if.right      = r_o_right;
    assign px_if.top        = r_o_top;
    assign px_if.bottom     = r_o_bottom;
    assign px_if.pix_count  = r_o_pix_count;
    assign px_if.box_valid  = r_o_box_valid;
    assign px_if.frame_done = r_o_frame_done;
    assign px_if.sync_err   = r_sync_err;

endmodule

// File: tb/tb_green_extent_tracker.sv
// Scoreboard bench for green_extent_tracker on a reduced 40x30 raster, MIN_COUNT=16.
module tb_green_extent_tracker;

    localparam int H = 40;
    localparam int V = 30;

    typedef struct {
        int l;
        int r;
        int t;
        int b;
        int c;
        int bv;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    green_extent_tracker_if px_if ();

    green_extent_tracker #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .MIN_COUNT(16)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .px_if(px_if)
    );

    exp_t q[$];
    int   n_checks  = 0;
    int   n_errs    = 0;
    int   sync_seen = 0;
    int   exp_sync  = 0;
    bit   prev_fd   = 1'b0;
    bit   prev_se   = 1'b0;

    function automatic void chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic exp_t mk(input int l, r, t, b, c, bv);
        exp_t e;
        e.l = l; e.r = r; e.t = t; e.b = b; e.c = c; e.bv = bv;
        return e;
    endfunction

    // Detection patterns: 0 box 10..19 x 5..14, 1 five scattered, 2 last-row tail,
    // 4 single frame-end pixel, 5 row 20 x 0..19.
    function automatic logic det(input int p, input int xx, input int yy);
        case (p)
            0: return (xx >= 10 && xx <= 19 && yy >= 5 && yy <= 14);
            1: return (xx == 3 && yy == 3) || (xx == 7 && yy == 8) || (xx == 20 && yy == 2)
                   || (xx == 1 && yy == 25) || (xx == 30 && yy == 10);
            2: return (yy == V - 1 && xx >= H - 16);
            4: return (xx == H - 1 && yy == V - 1);
            5: return (yy == 20 && xx <= 19);
            default: return 1'b0;
        endcase
    endfunction

    // Scoreboard monitor: pop and compare on every published frame.
    always @(negedge clk) begin
        if (px_if.frame_done) begin
            chk("frame_done_pulse_width", int'(prev_fd), 0);
            if (q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_frame_done: got pix_count %0d expected no publish",
                         px_if.pix_count);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("left",      int'(px_if.left),      e.l);
                chk("right",     int'(px_if.right),     e.r);
                chk("top",       int'(px_if.top),       e.t);
                chk("bottom",    int'(px_if.bottom),    e.b);
                chk("pix_count", int'(px_if.pix_count), e.c);
                chk("box_valid", int'(px_if.box_valid), e.bv);
            end
        end
        if (px_if.sync_err) begin
            sync_seen++;
            chk("sync_err_pulse_width", int'(prev_se), 0);
        end
        prev_fd = px_if.frame_done;
        prev_se = px_if.sync_err;
    end

    task automatic pix(input logic v, input logic d, input int xx, input int yy);
        px_if.in_valid = v;
        px_if.detected = d;
        px_if.x        = 10'(xx);
        px_if.y        = 10'(yy);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) pix(1'b0, 1'b0, 0, 0);
    endtask

    // Raster rows y0..y1; optional idle gaps and out-of-range noise, never after frame end.
    task automatic send_rows(input int p, input int y0, input int y1, input bit gaps);
        for (int yy = y0; yy <= y1; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                pix(1'b1, det(p, xx, yy), xx, yy);
                if (gaps && !(xx == H - 1 && yy == V - 1)) begin
                    if ($urandom_range(0, 7) == 0)  pix(1'b1, 1'b1, 700, yy);
                    if ($urandom_range(0, 15) == 0) pix(1'b1, 1'b1, 5, V);
                    idle(int'($urandom_range(0, 3)));
                end
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_left"},       int'(px_if.left),       0);
        chk({tag, "_right"},      int'(px_if.right),      0);
        chk({tag, "_top"},        int'(px_if.top),        0);
        chk({tag, "_bottom"},     int'(px_if.bottom),     0);
        chk({tag, "_pix_count"},  int'(px_if.pix_count),  0);
        chk({tag, "_box_valid"},  int'(px_if.box_valid),  0);
        chk({tag, "_frame_done"}, int'(px_if.frame_done), 0);
        chk({tag, "_sync_err"},   int'(px_if.sync_err),   0);
    endtask

    initial begin
        px_if.in_valid = 1'b0;
        px_if.detected = 1'b0;
        px_if.x        = '0;
        px_if.y        = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        idle(2);

        // Back-to-back frames: big box, small held box, exactly-MIN box.
        q.push_back(mk(10, 19, 5, 14, 100, 1));
        send_rows(0, 0, V - 1, 1'b0);
        q.push_back(mk(10, 19, 5, 14, 5, 0));
        send_rows(1, 0, V - 1, 1'b0);
        q.push_back(mk(24, 39, 29, 29, 16, 1));
        send_rows(2, 0, V - 1, 1'b0);
        // Idle after publish leaves the tracker accumulating, so the next (0,0) is a restart.
        idle(5);
        exp_sync++;
        q.push_back(mk(24, 39, 29, 29, 1, 0));
        send_rows(4, 0, V - 1, 1'b0);

        // Restart mid-frame: partial frame discarded, only the new frame reported.
        send_rows(0, 0, 15, 1'b1);
        exp_sync++;
        q.push_back(mk(0, 19, 20, 20, 20, 1));
        send_rows(5, 0, V - 1, 1'b1);

        // Reset mid-frame, resume mid-frame: nothing published until a full frame.
        send_rows(0, 0, 10, 1'b1);
        px_if.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send_rows(0, 11, V - 1, 1'b1);
        idle(4);
        check_zero("post_reset_resume");

        // Gapped stream with out-of-range noise matches the gap-free box.
        q.push_back(mk(10, 19, 5, 14, 100, 1));
        send_rows(0, 0, V - 1, 1'b1);

        for (int i = 0; i < 50 && q.size() != 0; i++) idle(1);
        idle(5);
        chk("scoreboard_drained", q.size(), 0);
        chk("sync_err_count", sync_seen, exp_sync);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
